// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: opcodes, ALU class encodings and the
// control bundle carried down the pipeline.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_J     = 6'h02;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'd0,
    ALUOP_BRANCH = 2'd1,
    ALUOP_RTYPE  = 2'd2
  } aluop_e;

  typedef struct packed {
    logic   reg_dst;
    logic   reg_write;
    logic   alu_src;
    logic   mem_read;
    logic   mem_write;
    logic   mem_to_reg;
    aluop_e alu_op;
  } ctrl_t;

  // Bits needed to hold 'value' (so clogb2(31) = 5).
  function automatic int clogb2(input int value);
    int res;
    res = 0;
    for (int v = value; v > 0; v = v >> 1) begin
      res++;
    end
    return res;
  endfunction

  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALUOP_RTYPE;
      end
      OP_LW: begin
        c.alu_src    = 1'b1;
        c.mem_read   = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      OP_ADDI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
      end
      OP_BEQ, OP_BNE: c.alu_op = ALUOP_BRANCH;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/id_stage_hazard_if.sv
// ID/EX pipeline-register bundle; the decode stage drives it as master and
// the execute stage consumes it as slave.
interface id_stage_hazard_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic [DATA_W-1:0] o_data_a;
  logic [DATA_W-1:0] o_data_b;
  logic [DATA_W-1:0] o_imm_ext;
  logic [REG_AW-1:0] o_rs;
  logic [REG_AW-1:0] o_rt;
  logic [REG_AW-1:0] o_rd;
  logic              o_RegDst;
  logic              o_RegWrite;
  logic              o_ALUSrc;
  logic              o_MemRead;
  logic              o_MemWrite;
  logic              o_MemtoReg;
  logic [1:0]        o_ALUOp;

  modport master (
    output o_data_a, o_data_b, o_imm_ext, o_rs, o_rt, o_rd,
    output o_RegDst, o_RegWrite, o_ALUSrc, o_MemRead, o_MemWrite, o_MemtoReg, o_ALUOp
  );

  modport slave (
    input o_data_a, o_data_b, o_imm_ext, o_rs, o_rt, o_rd,
    input o_RegDst, o_RegWrite, o_ALUSrc, o_MemRead, o_MemWrite, o_MemtoReg, o_ALUOp
  );
endinterface

// File: rtl/hazard_unit.sv
// Combinational load-use / branch-operand hazard detection and the
// EX/MEM-to-comparator forward selects.
module hazard_unit #(
  parameter int REG_AW = 5
) (
  input  logic              i_is_branch,
  input  logic              i_uses_rt,
  input  logic [REG_AW-1:0] i_rs,
  input  logic [REG_AW-1:0] i_rt,
  input  logic              i_idex_memread,
  input  logic              i_idex_regwrite,
  input  logic [REG_AW-1:0] i_idex_rd,
  input  logic              i_exmem_memtoreg,
  input  logic              i_exmem_regwrite,
  input  logic [REG_AW-1:0] i_exmem_rd,
  output logic              o_stall,
  output logic              o_fwd_a,
  output logic              o_fwd_b
);

  logic [1:0][REG_AW-1:0] src;
  logic [1:0]             br_stall;
  logic [1:0]             br_fwd;
  logic                   load_use;

  assign src = {i_rt, i_rs};

  assign load_use = i_idex_memread && (i_idex_rd != '0) &&
                    ((i_idex_rd == i_rs) || (i_uses_rt && (i_idex_rd == i_rt)));

  // The comparator sits in ID, so a branch source still in flight must either
  // be forwarded from an ALU result in MEM or waited for.
  for (genvar gi = 0; gi < 2; gi++) begin : g_src
    logic live;
    assign live         = i_is_branch && (src[gi] != '0);
    assign br_stall[gi] = live && ((i_idex_regwrite && (i_idex_rd == src[gi])) ||
                                   (i_exmem_regwrite && i_exmem_memtoreg && (i_exmem_rd == src[gi])));
    assign br_fwd[gi]   = live && i_exmem_regwrite && !i_exmem_memtoreg && (i_exmem_rd == src[gi]);
  end

  assign o_stall = load_use || (|br_stall);
  assign o_fwd_a = br_fwd[0];
  assign o_fwd_b = br_fwd[1];

endmodule

// File: rtl/id_stage_hazard.sv
// MIPS instruction-decode stage: register file with write-through, branch/jump
// resolution in ID, hazard stalls and the ID/EX register with bubble insertion.
module id_stage_hazard
  import mips_pkg::*;
#(
  parameter int  INSTR_W  = 32,
  parameter int  DATA_W   = 32,
  parameter int  NUM_REGS = 32,
  parameter int  ADDR_W   = 11,
  parameter int  IMM_W    = 16,
  parameter int  CNT_W    = 16,
  localparam int REG_AW   = clogb2(NUM_REGS - 1)
) (
  input  logic               i_clock,
  input  logic               i_soft_reset,
  input  logic               i_enable_pipeline,
  input  logic [INSTR_W-1:0] i_instruction,
  input  logic [ADDR_W-1:0]  i_pc_next,
  input  logic               i_wb_we,
  input  logic [REG_AW-1:0]  i_wb_addr,
  input  logic [DATA_W-1:0]  i_wb_data,
  input  logic               i_idex_memread,
  input  logic               i_idex_regwrite,
  input  logic [REG_AW-1:0]  i_idex_rd,
  input  logic               i_exmem_memtoreg,
  input  logic               i_exmem_regwrite,
  input  logic [REG_AW-1:0]  i_exmem_rd,
  input  logic [DATA_W-1:0]  i_exmem_alu,
  output logic               o_stall,
  output logic               o_flush_if,
  output logic               o_branch_taken,
  output logic [ADDR_W-1:0]  o_branch_dir,
  output logic [CNT_W-1:0]   o_stall_count,
  id_stage_hazard_if.master  idex
);

  logic [5:0]        opcode;
  logic [REG_AW-1:0] rs, rt, rd;
  logic [IMM_W-1:0]  imm;
  ctrl_t             dec_ctrl;
  logic              is_branch, uses_rt;

  assign opcode    = i_instruction[31:26];
  assign rs        = REG_AW'(i_instruction[25:21]);
  assign rt        = REG_AW'(i_instruction[20:16]);
  assign rd        = REG_AW'(i_instruction[15:11]);
  assign imm       = i_instruction[IMM_W-1:0];
  assign dec_ctrl  = decode_ctrl(opcode);
  assign is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign uses_rt   = (opcode == OP_RTYPE) || (opcode == OP_SW) || is_branch;

  logic [DATA_W-1:0] rf_q [NUM_REGS];
  logic [DATA_W-1:0] rf_d [NUM_REGS];

  always_comb begin
    rf_d = rf_q;
    if (i_enable_pipeline && i_wb_we && (i_wb_addr != '0)) begin
      rf_d[i_wb_addr] = i_wb_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_soft_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else begin
      rf_q <= rf_d;
    end
  end

  // Port 0 reads rs, port 1 reads rt; a same-cycle write-back is seen directly.
  logic [1:0][REG_AW-1:0] rd_addr;
  logic [1:0][DATA_W-1:0] rd_data;

  assign rd_addr = {rt, rs};

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd_port
    assign rd_data[gi] = (rd_addr[gi] == '0) ? '0 :
                         (i_wb_we && (i_wb_addr == rd_addr[gi])) ? i_wb_data :
                         rf_q[rd_addr[gi]];
  end

  logic hz_stall, fwd_a, fwd_b;

  hazard_unit #(.REG_AW(REG_AW)) u_hazard (
    .i_is_branch      (is_branch),
    .i_uses_rt        (uses_rt),
    .i_rs             (rs),
    .i_rt             (rt),
    .i_idex_memread   (i_idex_memread),
    .i_idex_regwrite  (i_idex_regwrite),
    .i_idex_rd        (i_idex_rd),
    .i_exmem_memtoreg (i_exmem_memtoreg),
    .i_exmem_regwrite (i_exmem_regwrite),
    .i_exmem_rd       (i_exmem_rd),
    .o_stall          (hz_stall),
    .o_fwd_a          (fwd_a),
    .o_fwd_b          (fwd_b)
  );

  logic [DATA_W-1:0] cmp_a, cmp_b;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_dir;

  assign cmp_a = fwd_a ? i_exmem_alu : rd_data[0];
  assign cmp_b = fwd_b ? i_exmem_alu : rd_data[1];

  always_comb begin
    branch_taken = 1'b0;
    branch_dir   = '0;
    if (i_enable_pipeline && !hz_stall) begin
      if (((opcode == OP_BEQ) && (cmp_a == cmp_b)) ||
          ((opcode == OP_BNE) && (cmp_a != cmp_b))) begin
        branch_taken = 1'b1;
        branch_dir   = i_pc_next + imm[ADDR_W-1:0];
      end else if (opcode == OP_J) begin
        branch_taken = 1'b1;
        branch_dir   = i_instruction[ADDR_W-1:0];
      end
    end
  end

  assign o_stall        = i_enable_pipeline && hz_stall;
  assign o_branch_taken = branch_taken;
  assign o_branch_dir   = branch_dir;
  assign o_flush_if     = branch_taken;

  logic [DATA_W-1:0] data_a_q, data_a_d, data_b_q, data_b_d, imm_ext_q, imm_ext_d;
  logic [REG_AW-1:0] rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // On a stall only the control bundle is zeroed; operand fields still load.
  always_comb begin
    data_a_d  = data_a_q;
    data_b_d  = data_b_q;
    imm_ext_d = imm_ext_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    ctrl_d    = ctrl_q;
    cnt_d     = cnt_q;
    if (i_enable_pipeline) begin
      data_a_d  = rd_data[0];
      data_b_d  = rd_data[1];
      imm_ext_d = {{(DATA_W - IMM_W){imm[IMM_W-1]}}, imm};
      rs_d      = rs;
      rt_d      = rt;
      rd_d      = rd;
      ctrl_d    = hz_stall ? '0 : dec_ctrl;
      if (hz_stall && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_soft_reset) begin
      data_a_q  <= '0;
      data_b_q  <= '0;
      imm_ext_q <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      ctrl_q    <= '0;
      cnt_q     <= '0;
    end else begin
      data_a_q  <= data_a_d;
      data_b_q  <= data_b_d;
      imm_ext_q <= imm_ext_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      ctrl_q    <= ctrl_d;
      cnt_q     <= cnt_d;
    end
  end

  assign o_stall_count   = cnt_q;
  assign idex.o_data_a   = data_a_q;
  assign idex.o_data_b   = data_b_q;
  assign idex.o_imm_ext  = imm_ext_q;
  assign idex.o_rs       = rs_q;
  assign idex.o_rt       = rt_q;
  assign idex.o_rd       = rd_q;
  assign idex.o_RegDst   = ctrl_q.reg_dst;
  assign idex.o_RegWrite = ctrl_q.reg_write;
  assign idex.o_ALUSrc   = ctrl_q.alu_src;
  assign idex.o_MemRead  = ctrl_q.mem_read;
  assign idex.o_MemWrite = ctrl_q.mem_write;
  assign idex.o_MemtoReg = ctrl_q.mem_to_reg;
  assign idex.o_ALUOp    = ctrl_q.alu_op;

endmodule

// File: tb/tb_id_stage_hazard.sv
// Bench for id_stage_hazard: directed scenarios then random cycles, all checked
// against a behavioural model of the decode stage.
module tb_id_stage_hazard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 11;
  localparam int CNT_W  = 8;
  localparam int REG_AW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, en;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] pc_next;
  logic              wb_we;
  logic [4:0]        wb_addr;
  logic [31:0]       wb_data;
  logic              idex_memread, idex_regwrite;
  logic [4:0]        idex_rd;
  logic              exmem_memtoreg, exmem_regwrite;
  logic [4:0]        exmem_rd;
  logic [31:0]       exmem_alu;
  logic              stall, flush_if, br_taken;
  logic [ADDR_W-1:0] br_dir;
  logic [CNT_W-1:0]  stall_count;

  id_stage_hazard_if #(.DATA_W(DATA_W), .REG_AW(REG_AW)) idex ();

  id_stage_hazard #(.CNT_W(CNT_W)) u_dut (
    .i_clock           (clk),
    .i_soft_reset      (rst),
    .i_enable_pipeline (en),
    .i_instruction     (instr),
    .i_pc_next         (pc_next),
    .i_wb_we           (wb_we),
    .i_wb_addr         (wb_addr),
    .i_wb_data         (wb_data),
    .i_idex_memread    (idex_memread),
    .i_idex_regwrite   (idex_regwrite),
    .i_idex_rd         (idex_rd),
    .i_exmem_memtoreg  (exmem_memtoreg),
    .i_exmem_regwrite  (exmem_regwrite),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_alu       (exmem_alu),
    .o_stall           (stall),
    .o_flush_if        (flush_if),
    .o_branch_taken    (br_taken),
    .o_branch_dir      (br_dir),
    .o_stall_count     (stall_count),
    .idex              (idex)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [31:0] m_rf [32];
  logic [31:0] e_a, e_b, e_imm;
  logic [4:0]  e_rs, e_rt, e_rd;
  logic [7:0]  e_ctrl;
  int          e_cnt;
  bit          c_stall, c_taken;
  int          c_dir;
  logic        obs_stall, obs_taken, obs_flush;
  logic [31:0] obs_dir;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {RegDst, RegWrite, ALUSrc, MemRead, MemWrite, MemtoReg, ALUOp[1:0]}
  function automatic logic [7:0] ref_ctrl(input logic [5:0] op);
    case (op)
      6'h00:        return 8'b1100_0010;
      6'h23:        return 8'b0111_0100;
      6'h2B:        return 8'b0010_1000;
      6'h08:        return 8'b0110_0000;
      6'h04, 6'h05: return 8'b0000_0001;
      default:      return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_we && wb_addr == a) return wb_data;
    return m_rf[a];
  endfunction

  task automatic model_comb();
    logic [5:0]  op;
    logic [4:0]  src [2];
    logic [31:0] val [2];
    bit          br, use_rt;
    op     = instr[31:26];
    src[0] = instr[25:21];
    src[1] = instr[20:16];
    br     = (op == 6'h04) || (op == 6'h05);
    use_rt = (op == 6'h00) || (op == 6'h2B) || br;
    c_stall = idex_memread && idex_rd != 0 &&
              (idex_rd == src[0] || (use_rt && idex_rd == src[1]));
    for (int k = 0; k < 2; k++) begin
      val[k] = m_read(src[k]);
      if (br && src[k] != 0) begin
        if (idex_regwrite && idex_rd == src[k]) c_stall = 1;
        if (exmem_regwrite && exmem_rd == src[k]) begin
          if (exmem_memtoreg) c_stall = 1;
          else val[k] = exmem_alu;
        end
      end
    end
    if (!en) c_stall = 0;
    c_taken = en && !c_stall && ((op == 6'h02) ||
              (op == 6'h04 && val[0] == val[1]) || (op == 6'h05 && val[0] != val[1]));
    if (!c_taken) c_dir = 0;
    else if (op == 6'h02) c_dir = int'(instr[ADDR_W-1:0]);
    else c_dir = (int'(pc_next) + int'(instr[15:0])) % (1 << ADDR_W);
  endtask

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      e_a = 0; e_b = 0; e_imm = 0; e_rs = 0; e_rt = 0; e_rd = 0; e_ctrl = 0; e_cnt = 0;
    end else if (en) begin
      e_a    = m_read(instr[25:21]);
      e_b    = m_read(instr[20:16]);
      e_imm  = {{16{instr[15]}}, instr[15:0]};
      e_rs   = instr[25:21];
      e_rt   = instr[20:16];
      e_rd   = instr[15:11];
      e_ctrl = c_stall ? 8'd0 : ref_ctrl(instr[31:26]);
      if (c_stall && e_cnt < (1 << CNT_W) - 1) e_cnt++;
      if (wb_we && wb_addr != 0) m_rf[wb_addr] = wb_data;
    end
  endtask

  task automatic step(input string tag);
    logic [7:0] got_ctrl;
    #1;
    model_comb();
    obs_stall = stall; obs_taken = br_taken; obs_flush = flush_if; obs_dir = 32'(br_dir);
    check({tag, ".stall"}, 32'(stall), 32'(c_stall));
    check({tag, ".taken"}, 32'(br_taken), 32'(c_taken));
    check({tag, ".flush"}, 32'(flush_if), 32'(c_taken));
    check({tag, ".dir"}, 32'(br_dir), c_dir);
    model_edge();
    @(posedge clk);
    #1;
    got_ctrl = {idex.o_RegDst, idex.o_RegWrite, idex.o_ALUSrc, idex.o_MemRead,
                idex.o_MemWrite, idex.o_MemtoReg, idex.o_ALUOp};
    check({tag, ".data_a"}, idex.o_data_a, e_a);
    check({tag, ".data_b"}, idex.o_data_b, e_b);
    check({tag, ".imm"}, idex.o_imm_ext, e_imm);
    check({tag, ".rs"}, 32'(idex.o_rs), 32'(e_rs));
    check({tag, ".rt"}, 32'(idex.o_rt), 32'(e_rt));
    check({tag, ".rd"}, 32'(idex.o_rd), 32'(e_rd));
    check({tag, ".ctrl"}, 32'(got_ctrl), 32'(e_ctrl));
    check({tag, ".count"}, 32'(stall_count), e_cnt);
    $display("[%0t] %s instr=%08h rst=%0d en=%0d stall=%0d taken=%0d dir=%03h ctrl=%02h cnt=%0d",
             $time, tag, instr, rst, en, obs_stall, obs_taken, obs_dir, got_ctrl, stall_count);
  endtask

  task automatic clear_inputs();
    rst = 0; en = 1; instr = 32'hFC00_0000; pc_next = '0;
    wb_we = 0; wb_addr = 0; wb_data = 0;
    idex_memread = 0; idex_regwrite = 0; idex_rd = 0;
    exmem_memtoreg = 0; exmem_regwrite = 0; exmem_rd = 0; exmem_alu = 0;
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {6'h00, s, t, d, 5'd0, 6'h20};
  endfunction

  function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] im);
    return {op, s, t, im};
  endfunction

  initial begin
    int saved_cnt;
    logic [5:0] op;
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    e_cnt = 0;

    // Reset with every input driven nonzero
    rst = 1; en = 1; instr = i_ins(6'h08, 5'd3, 5'd4, 16'h8001); pc_next = 11'h155;
    wb_we = 1; wb_addr = 5'd5; wb_data = 32'hAAAA_5555;
    idex_memread = 1; idex_regwrite = 1; idex_rd = 5'd3;
    exmem_memtoreg = 1; exmem_regwrite = 1; exmem_rd = 5'd4; exmem_alu = 32'h1;
    step("reset");
    check("reset_count", 32'(stall_count), 32'd0);
    check("reset_ctrl", 32'(idex.o_RegWrite), 32'd0);

    // Write-back bypass into both operands
    clear_inputs();
    wb_we = 1; wb_addr = 5'd5; wb_data = 32'h1234; instr = r_ins(5'd5, 5'd5, 5'd6);
    step("bypass");
    check("bypass_a", idex.o_data_a, 32'h1234);
    check("bypass_b", idex.o_data_b, 32'h1234);

    // Load-use: one stall cycle, bubble, count 1
    clear_inputs();
    idex_memread = 1; idex_rd = 5'd3; instr = r_ins(5'd3, 5'd1, 5'd4);
    step("loaduse");
    check("lu_stall", 32'(obs_stall), 32'd1);
    check("lu_bubble", 32'(idex.o_RegWrite), 32'd0);
    check("lu_count", 32'(stall_count), 32'd1);
    idex_memread = 0; idex_rd = 0;
    step("loaduse_release");
    check("lu_release_ctrl", 32'({idex.o_RegDst, idex.o_RegWrite}), 32'd3);

    // r2 = r7 = 9
    clear_inputs();
    wb_we = 1; wb_addr = 5'd2; wb_data = 32'd9; step("wr_r2");
    wb_addr = 5'd7; step("wr_r7");

    clear_inputs();
    pc_next = 11'h010; instr = i_ins(6'h04, 5'd2, 5'd7, 16'd4);
    step("beq_taken");
    check("beq_taken", 32'(obs_taken), 32'd1);
    check("beq_dir", obs_dir, 32'h014);
    check("beq_flush", 32'(obs_flush), 32'd1);

    exmem_regwrite = 1; exmem_rd = 5'd2; exmem_alu = 32'd5;
    step("beq_fwd");
    check("beq_fwd_taken", 32'(obs_taken), 32'd0);

    instr = i_ins(6'h05, 5'd2, 5'd0, 16'hFFFE);
    step("bne_fwd");
    check("bne_taken", 32'(obs_taken), 32'd1);
    check("bne_dir", obs_dir, 32'h00E);
    check("bne_stall", 32'(obs_stall), 32'd0);

    // Branch on a load in EX: stalls in EX and again in MEM, then resolves
    clear_inputs();
    pc_next = 11'h020; instr = i_ins(6'h04, 5'd2, 5'd7, 16'd8);
    idex_memread = 1; idex_regwrite = 1; idex_rd = 5'd2;
    step("br_load_ex");
    idex_memread = 0; idex_regwrite = 0; idex_rd = 0;
    exmem_regwrite = 1; exmem_memtoreg = 1; exmem_rd = 5'd2;
    step("br_load_mem");
    exmem_regwrite = 0; exmem_memtoreg = 0; exmem_rd = 0;
    step("br_load_go");
    check("br_load_taken", 32'(obs_taken), 32'd1);
    check("br_load_count", 32'(stall_count), 32'd3);

    // Pipeline disabled during a hazard: nothing moves, writes ignored
    saved_cnt = int'(stall_count);
    clear_inputs();
    en = 0; idex_memread = 1; idex_rd = 5'd3; instr = r_ins(5'd3, 5'd3, 5'd9);
    wb_we = 1; wb_addr = 5'd9; wb_data = 32'hDEAD;
    step("disabled0");
    check("dis_stall", 32'(obs_stall), 32'd0);
    instr = i_ins(6'h02, 5'd1, 5'd1, 16'h0123);
    step("disabled1");
    check("dis_count", 32'(stall_count), saved_cnt);
    check("dis_taken", 32'(obs_taken), 32'd0);
    clear_inputs();
    instr = r_ins(5'd9, 5'd0, 5'd10);
    step("dis_readback");
    check("dis_rf_hold", idex.o_data_a, 32'd0);

    // Saturating stall counter
    clear_inputs();
    idex_memread = 1; idex_rd = 5'd3; instr = r_ins(5'd3, 5'd1, 5'd4);
    for (int i = 0; i < (1 << CNT_W) + 4; i++) step("saturate");
    check("sat_count", 32'(stall_count), (1 << CNT_W) - 1);

    // Random cycles
    for (int i = 0; i < 1200; i++) begin
      rst = ($urandom_range(0, 99) < 3);
      en  = ($urandom_range(0, 9) != 0);
      case ($urandom_range(0, 7))
        0: op = 6'h00;  1: op = 6'h23;  2: op = 6'h2B;  3: op = 6'h08;
        4: op = 6'h04;  5: op = 6'h05;  6: op = 6'h02;
        default: op = 6'($urandom_range(0, 63));
      endcase
      instr   = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
      pc_next = ADDR_W'($urandom);
      wb_we   = 1'($urandom_range(0, 1));
      wb_addr = 5'($urandom_range(0, 7));
      wb_data = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      idex_memread   = ($urandom_range(0, 3) == 0);
      idex_regwrite  = 1'($urandom_range(0, 1));
      idex_rd        = 5'($urandom_range(0, 7));
      exmem_memtoreg = 1'($urandom_range(0, 1));
      exmem_regwrite = 1'($urandom_range(0, 1));
      exmem_rd       = 5'($urandom_range(0, 7));
      exmem_alu      = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
